// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared state and bus size encodings for the data SRAM bridge
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } bridgeState;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/data_sram_bridge_if.sv
// rtl/data_sram_bridge_if.sv - SoC-side SRAM-like split-transaction bus (req/addr_ok/data_ok)
interface data_sram_bridge_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          bus_req;
    logic          bus_wr;
    logic [1:0]    bus_size;
    logic [AW-1:0] bus_addr;
    logic [3:0]    bus_wstrb;
    logic [DW-1:0] bus_wdata;
    logic          bus_addr_ok;
    logic          bus_data_ok;
    logic [DW-1:0] bus_rdata;

    modport master (
        output bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/strb_size_dec.sv
// rtl/strb_size_dec.sv - byte-strobe pattern to bus transfer size and address offset
import bridge_pkg::*;

module strb_size_dec (
    input  logic [3:0] wen,
    output logic [1:0] size,
    output logic [1:0] offset
);
    // Reads (wen == 0) and partial-word swl/swr patterns fall to a full word.
    always_comb begin
        size   = SZ_WORD;
        offset = 2'd0;
        case (wen)
            4'b0001: begin size = SZ_BYTE; offset = 2'd0; end
            4'b0010: begin size = SZ_BYTE; offset = 2'd1; end
            4'b0100: begin size = SZ_BYTE; offset = 2'd2; end
            4'b1000: begin size = SZ_BYTE; offset = 2'd3; end
            4'b0011: begin size = SZ_HALF; offset = 2'd0; end
            4'b1100: begin size = SZ_HALF; offset = 2'd2; end
            default: begin size = SZ_WORD; offset = 2'd0; end
        endcase
    end
endmodule

// File: rtl/data_sram_bridge.sv
// rtl/data_sram_bridge.sv - M-stage data port to SRAM-like bus, one outstanding transaction
import bridge_pkg::*;

module data_sram_bridge #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          memen,
    input  logic [3:0]    wen,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          cancel,
    input  logic          cpu_hold,
    output logic [DW-1:0] rdata,
    output logic          d_stall,
    data_sram_bridge_if.master bus
);
    bridgeState state, nextState;
    logic [1:0] decSize;
    logic [1:0] decOffset;
    logic       issue;

    assign issue = memen & ~cancel;

    strb_size_dec uDec (
        .wen    (wen),
        .size   (decSize),
        .offset (decOffset)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    // DONE is held while the core is stalled so the still-asserted memen cannot re-issue.
    always_comb begin
        nextState = state;
        d_stall   = 1'b0;
        case (state)
            IDLE: begin
                d_stall = issue;
                if (issue) nextState = REQ;
            end
            REQ: begin
                d_stall = 1'b1;
                if (bus.bus_addr_ok) nextState = WAIT;
            end
            WAIT: begin
                d_stall = 1'b1;
                if (bus.bus_data_ok) nextState = DONE;
            end
            DONE: begin
                if (!cpu_hold) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.bus_req   <= 1'b0;
            bus.bus_wr    <= 1'b0;
            bus.bus_size  <= 2'd0;
            bus.bus_addr  <= '0;
            bus.bus_wstrb <= 4'd0;
            bus.bus_wdata <= '0;
        end else if (state == IDLE && issue) begin
            bus.bus_req   <= 1'b1;
            bus.bus_wr    <= |wen;
            bus.bus_size  <= decSize;
            bus.bus_addr  <= (addr & ~AW'(3)) | AW'(decOffset);
            bus.bus_wstrb <= wen;
            bus.bus_wdata <= wdata;
        end else if (state == REQ && bus.bus_addr_ok) begin
            bus.bus_req   <= 1'b0;
        end
    end

    // Write acks carry no data; rdata keeps the last read word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (state == WAIT && bus.bus_data_ok && !bus.bus_wr) begin
            rdata <= bus.bus_rdata;
        end
    end
endmodule

// File: tb/tb_data_sram_bridge.sv
// tb/tb_data_sram_bridge.sv - directed scoreboard bench for data_sram_bridge
module tb_data_sram_bridge;
    import bridge_pkg::*;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } reqT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memen = 1'b0;
    logic [3:0]  wen = 4'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        cancel = 1'b0;
    logic        cpu_hold = 1'b0;
    logic [31:0] rdata;
    logic        d_stall;

    int checks = 0;
    int passes = 0;
    int reqRises = 0;
    logic prevReq = 1'b0;
    logic [31:0] modelRdata = 32'd0;
    reqT expReq[$];
    logic [31:0] expRd[$];

    data_sram_bridge_if #(.AW(32), .DW(32)) bus ();

    data_sram_bridge #(.AW(32), .DW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .memen    (memen),
        .wen      (wen),
        .addr     (addr),
        .wdata    (wdata),
        .cancel   (cancel),
        .cpu_hold (cpu_hold),
        .rdata    (rdata),
        .d_stall  (d_stall),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.bus_req === 1'b1 && prevReq !== 1'b1) reqRises <= reqRises + 1;
        prevReq <= bus.bus_req;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic reqT curReq();
        return '{wr: bus.bus_wr, size: bus.bus_size, addr: bus.bus_addr,
                 wstrb: bus.bus_wstrb, wdata: bus.bus_wdata};
    endfunction

    task automatic access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] expSize, input logic [31:0] expAddr,
                          input logic [31:0] rd, input int aDly, input int dDly,
                          input int holdN, input bit cancelWait);
        reqT first;
        int  rises0, stalls, reqCyc, waitCyc, phase, cyc;
        expReq.push_back('{wr: (w != 4'd0), size: expSize, addr: expAddr, wstrb: w, wdata: d});
        if (w == 4'd0) modelRdata = rd;
        expRd.push_back(modelRdata);
        rises0 = reqRises;
        first = '0;
        memen = 1'b1; wen = w; addr = a; wdata = d; cancel = 1'b0; cpu_hold = 1'b0;
        #1;
        chk("stall_c0", 72'(d_stall), 72'(1));
        stalls = 1; phase = 0; reqCyc = 0; waitCyc = 0; cyc = 0;
        while (cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            bus.bus_addr_ok = 1'b0;
            bus.bus_data_ok = 1'b0;
            bus.bus_rdata   = 32'h0;
            if (phase == 0 && bus.bus_req === 1'b1) begin
                if (reqCyc == 0) begin
                    first = expReq.pop_front();
                    chk("req_fields", 72'(curReq()), 72'(first));
                end else begin
                    chk("req_stable", 72'(curReq()), 72'(first));
                end
                if (reqCyc == aDly) begin
                    bus.bus_addr_ok = 1'b1;
                    phase = 1;
                end
                reqCyc++;
            end else if (phase == 1) begin
                waitCyc++;
                if (cancelWait) cancel = 1'b1;
                if (waitCyc == dDly) begin
                    bus.bus_data_ok = 1'b1;
                    bus.bus_rdata   = (w == 4'd0) ? rd : 32'hBAD0BAD0;
                    phase = 2;
                end
            end
            #1;
            if (d_stall !== 1'b1) break;
            stalls++;
        end
        bus.bus_data_ok = 1'b0;
        chk("stall_cycles", 72'(stalls), 72'(2 + aDly + dDly));
        chk("done_reached", 72'(phase), 72'(2));
        chk("rdata_done", 72'(rdata), 72'(expRd.pop_front()));
        chk("req_low_done", 72'(bus.bus_req), 72'(0));
        cancel = 1'b0;
        cpu_hold = (holdN > 0);
        for (int i = 0; i < holdN - 1; i++) begin
            @(posedge clk); #1;
            chk("hold_stall", 72'({bus.bus_req, d_stall}), 72'(0));
            chk("hold_rdata", 72'(rdata), 72'(modelRdata));
        end
        cpu_hold = 1'b0;
        @(posedge clk); #1;
        // memen still high: IDLE shows d_stall=1 with no request yet.
        chk("idle_after", 72'({bus.bus_req, d_stall}), 72'(2'b01));
        memen = 1'b0; wen = 4'd0;
        #1;
        chk("one_req", 72'(reqRises - rises0), 72'(1));
    endtask

    initial begin
        int rises0;
        bus.bus_addr_ok = 1'b0;
        bus.bus_data_ok = 1'b0;
        bus.bus_rdata   = 32'h0;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_fields", 72'(curReq()), 72'(0));
        chk("rst_req_stall", 72'({bus.bus_req, d_stall}), 72'(0));
        chk("rst_rdata", 72'(rdata), 72'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        access(4'b0000, 32'h1FC0_0006, 32'h0,         SZ_WORD, 32'h1FC0_0004, 32'hDEADBEEF, 0, 1, 0, 0);
        access(4'b0100, 32'h0000_0010, 32'h00AB_0000, SZ_BYTE, 32'h0000_0012, 32'h0,        0, 1, 0, 0);
        access(4'b1100, 32'h0000_0010, 32'hABCD_0000, SZ_HALF, 32'h0000_0012, 32'h0,        0, 2, 0, 0);
        access(4'b0011, 32'h0000_0023, 32'h0000_1234, SZ_HALF, 32'h0000_0020, 32'h0,        1, 1, 0, 0);
        access(4'b1000, 32'h0000_0030, 32'h7700_0000, SZ_BYTE, 32'h0000_0033, 32'h0,        0, 1, 0, 0);
        access(4'b0001, 32'h0000_0031, 32'h0000_0055, SZ_BYTE, 32'h0000_0030, 32'h0,        0, 1, 0, 0);
        access(4'b0111, 32'h0000_0041, 32'h00A1_B2C3, SZ_WORD, 32'h0000_0040, 32'h0,        0, 1, 0, 0);
        access(4'b1111, 32'h0000_0048, 32'h0102_0304, SZ_WORD, 32'h0000_0048, 32'h0,        0, 1, 0, 0);
        access(4'b0000, 32'h0000_0200, 32'h0,         SZ_WORD, 32'h0000_0200, 32'h1234_5678, 3, 3, 0, 0);
        access(4'b0000, 32'h0000_0302, 32'h0,         SZ_WORD, 32'h0000_0300, 32'hCAFE_F00D, 0, 1, 5, 0);

        rises0 = reqRises;
        memen = 1'b1; cancel = 1'b1; wen = 4'b0000; addr = 32'h0000_0700;
        #1;
        chk("cancel_idle_stall", 72'(d_stall), 72'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("cancel_idle_req", 72'(bus.bus_req), 72'(0));
        chk("cancel_idle_rises", 72'(reqRises - rises0), 72'(0));
        memen = 1'b0; cancel = 1'b0;
        @(posedge clk); #1;

        access(4'b0000, 32'h0000_0400, 32'h0, SZ_WORD, 32'h0000_0400, 32'h0BAD_F00D, 0, 2, 0, 1);

        memen = 1'b1; wen = 4'b0000; addr = 32'h0000_0800;
        @(posedge clk); #1;
        chk("rstmid_req", 72'(bus.bus_req), 72'(1));
        bus.bus_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus.bus_addr_ok = 1'b0;
        rst = 1'b0; memen = 1'b0;
        modelRdata = 32'h0;
        #1;
        chk("rstmid_async", 72'({bus.bus_req, d_stall}), 72'(0));
        chk("rstmid_rdata", 72'(rdata), 72'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        bus.bus_data_ok = 1'b1;
        bus.bus_rdata   = 32'h5555_5555;
        @(posedge clk); #1;
        bus.bus_data_ok = 1'b0;
        bus.bus_rdata   = 32'h0;
        chk("late_dataok_rdata", 72'(rdata), 72'(0));
        chk("late_dataok_idle", 72'({bus.bus_req, d_stall}), 72'(0));

        access(4'b0000, 32'h0000_0500, 32'h0, SZ_WORD, 32'h0000_0500, 32'h600D_CAFE, 0, 1, 0, 0);

        chk("scoreboard_empty", 72'(expReq.size() + expRd.size()), 72'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
